// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle for alu_ctrl_seq: op request towards the ALU
// sequencer and the registered result/status coming back.
interface alu_ctrl_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       gout;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (
    output start, aluop, funct, a, b,
    input  gout, result, zero, busy, done, illegal
  );

  modport slave (
    input  start, aluop, funct, a, b,
    output gout, result, zero, busy, done, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a sequenced datapath: single-cycle arithmetic/logic
// ops and a bit-serial variable shifter that advances one position per cycle.
module alu_ctrl_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  alu_ctrl_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] G_AND  = 3'b000;
  localparam logic [2:0] G_OR   = 3'b001;
  localparam logic [2:0] G_ADD  = 3'b010;
  localparam logic [2:0] G_SLL  = 3'b100;
  localparam logic [2:0] G_SRL  = 3'b101;
  localparam logic [2:0] G_SUB  = 3'b110;
  localparam logic [2:0] G_SLT  = 3'b111;

  // Returns {legal, gout}; illegal encodings fall back to the add code.
  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] f);
    logic [3:0] d;
    case (op)
      2'b00:   d = {1'b1, G_ADD};
      2'b01:   d = {1'b1, G_SUB};
      2'b11:   d = {1'b1, G_AND};
      default: begin
        casez (f)
          6'b??0000: d = {1'b1, G_ADD};
          6'b??0010: d = {1'b1, G_SUB};
          6'b1?0100: d = {1'b1, G_AND};
          6'b??0101: d = {1'b1, G_OR};
          6'b??1010: d = {1'b1, G_SLT};
          6'b000100: d = {1'b1, G_SLL};
          6'b000110: d = {1'b1, G_SRL};
          default:   d = {1'b0, G_ADD};
        endcase
      end
    endcase
    return d;
  endfunction

  // Single-cycle result; shift codes only reach here with a zero amount.
  function automatic logic [WIDTH-1:0] alu(input logic [2:0] g,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    logic [WIDTH-1:0]        r;
    sx = x;
    sy = y;
    case (g)
      G_ADD:   r = x + y;
      G_SUB:   r = x - y;
      G_AND:   r = x & y;
      G_OR:    r = x | y;
      G_SLT:   r = {{(WIDTH-1){1'b0}}, (sx < sy)};
      default: r = x;
    endcase
    return r;
  endfunction

  state_t           state;
  logic [2:0]       gout_p0;
  logic [WIDTH-1:0] result_p0;
  logic             zero_p0;
  logic             busy_p0;
  logic             vld_p0;
  logic             illegal_p0;
  logic [WIDTH-1:0] sh_reg;
  logic [SHW-1:0]   count;
  logic             sh_left;

  logic [3:0]       dec;
  logic             legal;
  logic [2:0]       code;
  logic             is_shift;
  logic [SHW-1:0]   n;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sh_next;
  logic             accept;

  always_comb begin
    dec      = decode(bus.aluop, bus.funct);
    legal    = dec[3];
    code     = dec[2:0];
    is_shift = legal && (code == G_SLL || code == G_SRL);
    n        = bus.b[SHW-1:0];
    alu_res  = legal ? alu(code, bus.a, bus.b) : '0;
    sh_next  = sh_left ? (sh_reg << 1) : (sh_reg >> 1);
    accept   = bus.start && (state != SHIFT);
  end

  // Acceptance edge: decode and either finish immediately or load the shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gout_p0    <= G_ADD;
      result_p0  <= '0;
      zero_p0    <= 1'b0;
      busy_p0    <= 1'b0;
      vld_p0     <= 1'b0;
      illegal_p0 <= 1'b0;
      count      <= '0;
      sh_left    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          vld_p0 <= 1'b0;
          if (accept) begin
            gout_p0    <= code;
            illegal_p0 <= !legal;
            if (is_shift && n != '0) begin
              sh_reg  <= bus.a;
              count   <= n;
              sh_left <= (code == G_SLL);
              busy_p0 <= 1'b1;
              state   <= SHIFT;
            end else begin
              result_p0 <= alu_res;
              zero_p0   <= (alu_res == '0);
              vld_p0    <= 1'b1;
              state     <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // The final step writes straight into the result register
          if (count == SHW'(1)) begin
            result_p0 <= sh_next;
            zero_p0   <= (sh_next == '0);
            vld_p0    <= 1'b1;
            busy_p0   <= 1'b0;
            count     <= '0;
            state     <= DONE;
          end else begin
            sh_reg <= sh_next;
            count  <= count - SHW'(1);
          end
        end
        default: begin
          vld_p0  <= 1'b0;
          busy_p0 <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.gout    = gout_p0;
  assign bus.result  = result_p0;
  assign bus.zero    = zero_p0;
  assign bus.busy    = busy_p0;
  assign bus.done    = vld_p0;
  assign bus.illegal = illegal_p0;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed and randomized bench for alu_ctrl_seq (32-bit and 8-bit builds)
// against an arithmetic reference model of the decode and latency rules.
module tb_alu_ctrl_seq;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_ctrl_seq_if #(.WIDTH(32)) bus ();
  alu_ctrl_seq_if #(.WIDTH(8))  bus8 ();

  alu_ctrl_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  alu_ctrl_seq #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  g;
    logic [31:0] r;
    logic        ill;
    logic [7:0]  lat;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // Reference: op class and funct rules evaluated with plain arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int   low;
    int   n;
    low   = int'(f) % 16;
    n     = int'(bv % 32);
    e.ill = 1'b0;
    e.lat = 8'd1;
    if (op == 2'd0)                        begin e.g = 3'b010; e.r = av + bv; end
    else if (op == 2'd1)                   begin e.g = 3'b110; e.r = av - bv; end
    else if (op == 2'd3)                   begin e.g = 3'b000; e.r = av & bv; end
    else if (low == 0)                     begin e.g = 3'b010; e.r = av + bv; end
    else if (low == 2)                     begin e.g = 3'b110; e.r = av - bv; end
    else if (low == 4 && f >= 6'd32)       begin e.g = 3'b000; e.r = av & bv; end
    else if (low == 5)                     begin e.g = 3'b001; e.r = av | bv; end
    else if (low == 10) begin
      e.g = 3'b111;
      e.r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
    end
    else if (f == 6'd4) begin e.g = 3'b100; e.r = av << n; e.lat = 8'(n + 1); end
    else if (f == 6'd6) begin e.g = 3'b101; e.r = av >> n; e.lat = 8'(n + 1); end
    else begin e.g = 3'b010; e.r = 32'd0; e.ill = 1'b1; end
    return e;
  endfunction

  // Called on a falling edge; leaves on the falling edge where done is seen.
  task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] av, input logic [31:0] bv, input bit hammer);
    exp_t e;
    int   lat;
    e = model(op, f, av, bv);
    bus.start = 1'b1; bus.aluop = op; bus.funct = f; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    check("gout_at_accept", 64'(bus.gout), 64'(e.g));
    lat = 1;
    while (!bus.done && lat < 80) begin
      check("busy_during_shift", 64'(bus.busy), 64'd1);
      if (hammer) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.aluop = 2'($urandom);
        bus.funct = 6'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'(e.lat));
    check("result", 64'(bus.result), 64'(e.r));
    check("zero", 64'(bus.zero), 64'(e.r == 32'd0));
    check("illegal", 64'(bus.illegal), 64'(e.ill));
    check("gout_at_done", 64'(bus.gout), 64'(e.g));
    check("busy_at_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gout"},    64'(bus.gout),    64'd2);
    check({tag, "_result"},  64'(bus.result),  64'd0);
    check({tag, "_busy"},    64'(bus.busy),    64'd0);
    check({tag, "_done"},    64'(bus.done),    64'd0);
    check({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
    check({tag, "_zero"},    64'(bus.zero),    64'd0);
  endtask

  logic [5:0] legal_f [12];
  int         seen_done;

  initial begin
    total = 0;
    bad   = 0;
    legal_f = '{6'd0, 6'd2, 6'd36, 6'd5, 6'd10, 6'd4, 6'd6,
                6'd48, 6'd18, 6'd52, 6'd37, 6'd26};
    reset = 1'b1;
    bus.start = 1'b0;  bus.aluop = 2'd0;  bus.funct = 6'd0;  bus.a = '0;  bus.b = '0;
    bus8.start = 1'b0; bus8.aluop = 2'd0; bus8.funct = 6'd0; bus8.a = '0; bus8.b = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst0");
    check("rst0_w8_result", 64'(bus8.result), 64'd0);
    reset = 1'b0;

    // Add 5+7 issued on the edge right after reset release
    run_op(2'b00, 6'd0, 32'd5, 32'd7, 1'b0);
    check("add_5_7", 64'(bus.result), 64'd12);

    // Signed slt -1<1, then back-to-back sub 9-9
    run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("slt_neg", 64'(bus.result), 64'd1);
    run_op(2'b01, 6'd0, 32'd9, 32'd9, 1'b0);
    check("sub_zero", 64'(bus.zero), 64'd1);

    // sllv by 4 with upper b bits set
    run_op(2'b10, 6'b000100, 32'h1, 32'h24, 1'b0);
    check("sllv_4", 64'(bus.result), 64'h10);
    @(negedge clk);
    @(negedge clk);
    check("hold_result", 64'(bus.result), 64'h10);
    check("hold_gout", 64'(bus.gout), 64'd4);
    check("hold_done_low", 64'(bus.done), 64'd0);

    // Illegal funct, then a legal op clears it
    run_op(2'b10, 6'b000111, 32'h1234, 32'h5678, 1'b0);
    run_op(2'b11, 6'd0, 32'hF0F0, 32'h0FF0, 1'b0);

    // Shift by 31; start ignored while busy; reset in its 10th cycle
    bus.start = 1'b1; bus.aluop = 2'b10; bus.funct = 6'b000100; bus.a = 32'h1; bus.b = 32'd31;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.aluop = 2'b00; bus.a = 32'd1; bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_ignored_busy", 64'(bus.busy), 64'd1);
    check("start_ignored_gout", 64'(bus.gout), 64'd4);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst_mid");
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1;
    end
    check("no_done_after_abort", 64'(seen_done), 64'd0);

    // Width-8 build: srlv by 1 with ignored upper b bits, then back-to-back add
    bus8.start = 1'b1; bus8.aluop = 2'b10; bus8.funct = 6'b000110; bus8.a = 8'h80; bus8.b = 8'hF9;
    @(negedge clk);
    bus8.start = 1'b0;
    check("w8_busy", 64'(bus8.busy), 64'd1);
    check("w8_done_early", 64'(bus8.done), 64'd0);
    @(negedge clk);
    check("w8_done", 64'(bus8.done), 64'd1);
    check("w8_srlv", 64'(bus8.result), 64'h40);
    check("w8_gout", 64'(bus8.gout), 64'd5);
    bus8.start = 1'b1; bus8.aluop = 2'b00; bus8.a = 8'hF0; bus8.b = 8'h25;
    @(negedge clk);
    bus8.start = 1'b0;
    check("w8_b2b_done", 64'(bus8.done), 64'd1);
    check("w8_b2b_add", 64'(bus8.result), 64'h15);
    check("w8_b2b_gout", 64'(bus8.gout), 64'd2);

    // Randomized ops, mixed back-to-back and idle gaps
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [5:0]  f;
      logic [31:0] av;
      logic [31:0] bv;
      op = 2'($urandom);
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 11)];
      av = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? av : $urandom;
      if ($urandom_range(0, 7) == 0) av = 32'h8000_0000;
      run_op(op, f, av, bv, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("idle_done_low", 64'(bus.done), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
